instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 15 +
 rtl/instruction_fetch_unit_if.sv | 18 +
 rtl/instruction_fetch_unit_timeout.sv | 29 ++
 rtl/instruction_fetch_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, opcode
// field width and wait-counter sizing.
package instruction_fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      VALID    = 2'd2
   } fetch_state_t;

   localparam int OPCODE_W        = 6;
   localparam int TIMEOUT_DEFAULT = 15;
   localparam int WAIT_CNT_W      = 4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
interface instruction_fetch_unit_if #(
   parameter int ADDR_W  = 10,
   parameter int INSTR_W = 32
);

   // Handshake: the master raises mem_req and holds mem_req/mem_addr stable until
   // it samples mem_ack=1 on a rising edge; mem_rdata is valid only in that cycle.
   // mem_ack while mem_req=0 carries no meaning and is ignored by the master.
   logic               mem_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic [INSTR_W-1:0] mem_rdata;
   logic               mem_ack;

   modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
   modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);

endinterface

// File: rtl/instruction_fetch_unit_timeout.sv
// Wait counter for outstanding memory reads; flags the cycle whose
// increment brings the count to TIMEOUT.
module fetch_timeout_counter
   import instruction_fetch_unit_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [WAIT_CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // Asserted one cycle early so the fetch FSM can register fetch_err on the
   // same edge at which the count reaches TIMEOUT.
   assign expired = enable && (count == WAIT_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: requests the word at PC, holds it in the IR until the
// control unit takes it, and handles branch loads and memory timeouts.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int               ADDR_W   = 10,
   parameter int               INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int               TIMEOUT  = TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_en,
   input  logic                  instr_taken,
   input  logic                  pc_load,
   input  logic [ADDR_W-1:0]     pc_load_addr,
   instruction_fetch_unit_if.master mem,
   output logic [OPCODE_W-1:0]   OPCode,
   output logic [ADDR_W-1:0]     operand,
   output logic [ADDR_W-1:0]     pc,
   output logic                  instr_valid,
   output logic                  fetch_err,
   output logic [INSTR_W-1:0]    ir,
   output fetch_state_t          state
);

   logic              load_pend;
   logic [ADDR_W-1:0] load_addr_q;
   logic [ADDR_W-1:0] fetch_addr;
   logic              start_fetch;
   logic              wait_en;
   logic              wait_expired;

   assign fetch_addr  = pc_load ? pc_load_addr : pc;
   assign start_fetch = fetch_en && ((state == IDLE) || ((state == VALID) && instr_taken));
   assign wait_en     = (state == WAIT_ACK) && !mem.mem_ack;

   fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (start_fetch),
      .enable  (wait_en),
      .expired (wait_expired)
   );

   // Fields come straight off the IR so they line up with instr_valid.
   assign OPCode  = ir[INSTR_W-1 -: OPCODE_W];
   assign operand = ir[ADDR_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         ir           <= '0;
         mem.mem_addr <= '0;
         mem.mem_req  <= 1'b0;
         instr_valid  <= 1'b0;
         fetch_err    <= 1'b0;
         load_pend    <= 1'b0;
         load_addr_q  <= '0;
      end else begin
         fetch_err <= 1'b0;
         case (state)
            IDLE, VALID: begin
               if (pc_load) pc <= pc_load_addr;
               if (start_fetch) begin
                  mem.mem_addr <= fetch_addr;
                  mem.mem_req  <= 1'b1;
                  instr_valid  <= 1'b0;
                  state        <= WAIT_ACK;
               end else if ((state == VALID) && instr_taken) begin
                  instr_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            WAIT_ACK: begin
               if (mem.mem_ack) begin
                  ir <= mem.mem_rdata;
                  // A branch seen during the read overrides the sequential PC.
                  if (pc_load)        pc <= pc_load_addr;
                  else if (load_pend) pc <= load_addr_q;
                  else                pc <= mem.mem_addr + ADDR_W'(1);
                  load_pend   <= 1'b0;
                  mem.mem_req <= 1'b0;
                  instr_valid <= 1'b1;
                  state       <= VALID;
               end else if (wait_expired) begin
                  load_pend   <= 1'b0;
                  mem.mem_req <= 1'b0;
                  fetch_err   <= 1'b1;
                  state       <= IDLE;
               end else if (pc_load) begin
                  load_pend   <= 1'b1;
                  load_addr_q <= pc_load_addr;
               end
            end
            default: begin
               mem.mem_req <= 1'b0;
               instr_valid <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule
